// File: rtl/score_event_arbiter.sv
// score_event_arbiter: merges per-source point events into one clamped signed score delta stream.
// Optional SCORE_FRAME_SYNC_EN restricts grants to a NUM_REQ-cycle window after startOfFrame.
module score_event_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int SCORE_MAX = 9999,
  parameter int LIFE_STEP = 1000
) (
  input  logic                   clk,
  input  logic                   resetN,
  input  logic                   startOfFrame,
  input  logic                   newGame,
  input  logic [NUM_REQ-1:0]     evtValid,
  input  logic [NUM_REQ*8-1:0]   evtPoints,
  output logic [NUM_REQ-1:0]     evtReady,
  output logic signed [7:0]      scoreUpdate,
  output logic                   resetScore,
  output logic [13:0]            shadowScore,
  output logic [13:0]            highScore,
  output logic                   extraLife,
  output logic                   busy
);
  localparam int PW = $clog2(NUM_REQ);
  logic [NUM_REQ-1:0] slot_full, gnt_oh;
  logic signed [7:0] slot_pts [NUM_REQ];
  logic [PW-1:0] ptr, gnt_idx, cand;
  logic gnt_vld, win_open, life_hit;
  logic signed [15:0] next_life, cur, pts_ext, sum, new_s;
  logic signed [7:0] delta;
`ifdef SCORE_FRAME_SYNC_EN
  logic [PW:0] win_cnt;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) win_cnt <= '0;
    else if (startOfFrame) win_cnt <= (PW+1)'(NUM_REQ);
    else if (win_cnt != '0) win_cnt <= win_cnt - 1'b1;
  end
  assign win_open = win_cnt != '0;
`else
  logic unused_sof;
  assign unused_sof = startOfFrame;
  assign win_open = 1'b1;
`endif
  // first full slot at or after the round-robin pointer
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = PW'((int'(ptr) + k) % NUM_REQ);
      if (win_open && slot_full[cand]) begin
        gnt_vld = 1'b1;
        gnt_idx = cand;
      end
    end
  end
  assign gnt_oh   = NUM_REQ'(gnt_vld) << gnt_idx;
  assign cur      = $signed({2'b00, shadowScore});
  assign pts_ext  = 16'(slot_pts[gnt_idx]);
  assign sum      = cur + pts_ext;
  assign new_s    = sum > 16'(SCORE_MAX) ? 16'(SCORE_MAX) : sum < 16'sd0 ? 16'sd0 : sum;
  assign delta    = 8'(new_s - cur);
  assign life_hit = gnt_vld && new_s >= next_life;
  assign evtReady = ~slot_full;
  assign busy     = |slot_full;
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      slot_full   <= '0;
      ptr         <= '0;
      next_life   <= 16'(LIFE_STEP);
      shadowScore <= '0;
      scoreUpdate <= '0;
      resetScore  <= 1'b0;
      extraLife   <= 1'b0;
    end else if (newGame) begin
      slot_full   <= '0;
      ptr         <= '0;
      next_life   <= 16'(LIFE_STEP);
      shadowScore <= '0;
      scoreUpdate <= '0;
      resetScore  <= 1'b1;
      extraLife   <= 1'b0;
    end else begin
      slot_full   <= (slot_full | (evtValid & evtReady)) & ~gnt_oh;
      resetScore  <= 1'b0;
      scoreUpdate <= gnt_vld ? delta : '0;
      extraLife   <= life_hit;
      if (gnt_vld) begin
        shadowScore <= new_s[13:0];
        ptr         <= gnt_idx == PW'(NUM_REQ - 1) ? '0 : gnt_idx + 1'b1;
      end
      if (life_hit) next_life <= next_life + 16'(LIFE_STEP);
    end
  end
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_REQ; i++)
      if (evtValid[i] && evtReady[i] && !newGame) slot_pts[i] <= evtPoints[8*i +: 8];
  end
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) highScore <= '0;
    else if (shadowScore > highScore) highScore <= shadowScore;
  end
endmodule

// File: doc/score_event_arbiter.md
# score_event_arbiter

Collects point events from several game-logic sources (alien hits, UFO hits, player-death penalty, wave bonus) and serialises them into the single signed per-cycle `scoreUpdate` stream consumed by the score digit display block. It keeps a shadow copy of the score so every update is clamped to the 4-digit display range 0..SCORE_MAX. It also generates the one-cycle `resetScore` pulse on a new game, tracks the high score, and signals extra-life thresholds. It sits between the game-logic objects and the score bitmap, one instance per player.

## Interface
- NUM_REQ, 4, number of event sources (2..8)
- SCORE_MAX, 9999, upper clamp of shadow score
- LIFE_STEP, 1000, extra-life threshold step; must be >127
- clk  in  1  system clock
- resetN  in  1  reset, asynchronous, active-low
- startOfFrame  in  1  one-cycle pulse at frame start
- newGame  in  1  one-cycle pulse: clear score and flush events
- evtValid  in  NUM_REQ  per-source event valid; held until accepted
- evtPoints  in  NUM_REQ×8  per-source signed 8-bit points, packed; source i at bits [8i+7:8i]
- evtReady  out  NUM_REQ  per-source slot empty; registered
- scoreUpdate  out  8 signed  clamped delta for the score block; 0 when idle
- resetScore  out  1  one-cycle clear pulse to the score block
- shadowScore  out  14  current clamped score
- highScore  out  14  maximum shadowScore since resetN
- extraLife  out  1  one-cycle pulse on crossing a LIFE_STEP multiple
- busy  out  1  any slot full

## Operation
- Reset values: slots empty, evtReady all 1, scoreUpdate 0, resetScore 0, shadowScore 0, highScore 0, extraLife 0, busy 0. Internal state: RR pointer 0, nextLife = LIFE_STEP.
- Each source has a one-entry slot. A transfer occurs on `evtValid[i] & evtReady[i]`. The slot latches `evtPoints[i]`, and `evtReady[i]` drops the next cycle.
- Round-robin grant, when the grant window is allowed:
  - Search full slots starting at the pointer.
  - Grant one slot per cycle and clear it.
  - Set pointer to granted index + 1, wrapping at NUM_REQ.
- Clamp, for a granted slot with old score s and points p:
  - If s+p > SCORE_MAX, then d = SCORE_MAX − s.
  - If s+p < 0, then d = −s.
  - Otherwise d = p.
  - Compute in ≥16-bit signed arithmetic. |d| ≤ 128 always fits 8-bit signed.
- Register outputs: scoreUpdate <= d and shadowScore <= s+d. scoreUpdate returns to 0 on the next non-grant cycle. A grant with d = 0 still clears the slot and outputs 0.
- Extra life: if s+d ≥ nextLife, pulse extraLife in the same cycle as scoreUpdate and advance nextLife by LIFE_STEP. Penalties never lower nextLife.
- highScore <= max(highScore, shadowScore) every cycle. Only resetN clears it.
- newGame has priority over everything:
  - Next cycle: resetScore = 1 and scoreUpdate = 0.
  - shadowScore = 0, all slots are emptied, pointer = 0, nextLife = LIFE_STEP.
  - evtValid in the newGame cycle is not accepted. No grant occurs in the newGame cycle.
- resetScore and a non-zero scoreUpdate are never asserted in the same cycle.
- A refill of a slot in the same cycle as its grant is not allowed: evtReady is low that cycle, so the refill transfers at the earliest one cycle later.

## Timing
- Transfer at edge N → earliest grant at edge N+1 → scoreUpdate / shadowScore / extraLife valid from edge N+1 for one cycle.
- The downstream score block adds scoreUpdate one edge later, so its score equals shadowScore delayed by one cycle.
- With NUM_REQ slots full, draining takes NUM_REQ consecutive grant cycles.
- resetN asserted mid-drain: all state returns to reset values asynchronously, and pending events are lost.

## Configuration
- SCORE_FRAME_SYNC_EN defined:
  - Grants are allowed only during a window of NUM_REQ cycles starting the cycle after startOfFrame. Score changes therefore land at the top of the frame with no digit tearing.
  - Slots still accept events at any time.
  - Events still pending at window end wait for the next frame.
  - A startOfFrame pulse during an open window restarts the window at full length.
- Not defined: the grant window is always open, and startOfFrame is unused.

## Test plan
- Source 0 sends +10 with shadowScore 0 → one cycle later scoreUpdate = 10 for exactly one cycle; shadowScore = 10; evtReady[0] low one cycle.
- All four sources send +1,+2,+3,+4 in the same cycle, pointer 0 → scoreUpdate = 1,2,3,4 on four consecutive cycles; shadowScore = 10; pointer ends at 0.
- shadowScore 9990 and event +50 → scoreUpdate = 9, shadowScore = 9999. Then event −128 → scoreUpdate = −128, shadowScore = 9871.
- shadowScore 5 and event −20 → scoreUpdate = −5, shadowScore = 0. shadowScore 980 and event +30 → extraLife pulse once, nextLife = 2000.
- Slots 1 and 2 full, newGame pulse → resetScore = 1 for one cycle, no scoreUpdate from flushed slots, shadowScore = 0, highScore unchanged.
- With SCORE_FRAME_SYNC_EN and NUM_REQ = 4: five events pending (refill slot 0 after grant) → four grants in the window after startOfFrame, fifth grant only after the next startOfFrame.
